// File: rtl/score_tracker.sv
// Game-status and BCD score controller feeding the display driver.
// Optional LED blink in OVER is enabled by defining SCORE_BLINK_EN.
module score_tracker #(
  parameter int MAX_SCORE = 32,
  parameter int LIVES     = 10,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  input  logic             userquit,
  input  logic             match,
  input  logic             miss,
  output logic             ingameOn,
  output logic             gameOver,
  output logic [3:0]       hex0hldr,
  output logic [3:0]       hex4hldr,
  output logic [3:0]       hex5hldr,
  output logic [LIVES-1:0] ledrhldr
);

  localparam int LW = $clog2(LIVES + 1);
  localparam logic [3:0]    MAX_T     = 4'(MAX_SCORE / 10);
  localparam logic [3:0]    MAX_O     = 4'(MAX_SCORE % 10);
  localparam logic [LW-1:0] LIVES_INI = LW'(LIVES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER, S_QUIT} state_t;

  state_t          r_state, w_state_next;
  logic            r_start_q, r_quit_q;
  logic [3:0]      r_tens, r_ones, w_tens_next, w_ones_next;
  logic [LW-1:0]   r_lives, w_lives_next;
  logic [3:0]      r_hex0, w_hex0_next;
  logic            r_ingame, r_over;
  logic [LIVES-1:0] r_ledr, w_therm;
  logic            w_start_edge, w_quit_edge, w_blank;

  assign w_start_edge = start & ~r_start_q;
  assign w_quit_edge  = userquit & ~r_quit_q;

  always_comb begin
    w_state_next = r_state;
    w_tens_next  = r_tens;
    w_ones_next  = r_ones;
    w_lives_next = r_lives;
    case (r_state)
      S_PLAY: begin
        // Quit wins over match/miss arriving in the same cycle.
        if (w_quit_edge) begin
          w_state_next = S_QUIT;
        end else begin
          if (match && !(r_tens == MAX_T && r_ones == MAX_O)) begin
            if (r_ones == 4'd9) begin
              w_ones_next = 4'd0;
              w_tens_next = r_tens + 4'd1;
            end else begin
              w_ones_next = r_ones + 4'd1;
            end
          end
          if (miss && r_lives != '0)
            w_lives_next = r_lives - 1'b1;
          if ((w_tens_next == MAX_T && w_ones_next == MAX_O) || w_lives_next == '0)
            w_state_next = S_OVER;
        end
      end
      default: begin
        if (w_start_edge) begin
          w_state_next = S_PLAY;
          w_tens_next  = 4'd0;
          w_ones_next  = 4'd0;
          w_lives_next = LIVES_INI;
        end
      end
    endcase
  end

  always_comb begin
    w_hex0_next = 4'h0;
    case (w_state_next)
      S_PLAY:  w_hex0_next = 4'h1;
      S_OVER:  w_hex0_next = 4'hE;
      S_QUIT:  w_hex0_next = 4'hF;
      default: w_hex0_next = 4'h0;
    endcase
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < LIVES; i++)
      w_therm[i] = (i < int'(w_lives_next));
  end

`ifdef SCORE_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [CW-1:0] r_blink_cnt, w_blink_cnt_next;
  logic          r_blink, w_blink_next;

  // Phase restarts "on" every time OVER is entered.
  always_comb begin
    w_blink_cnt_next = '0;
    w_blink_next     = 1'b0;
    if (r_state == S_OVER && w_state_next == S_OVER) begin
      if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
        w_blink_next = ~r_blink;
      end else begin
        w_blink_cnt_next = r_blink_cnt + 1'b1;
        w_blink_next     = r_blink;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_cnt_next;
      r_blink     <= w_blink_next;
    end
  end

  assign w_blank = w_blink_next;
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_quit_q  <= 1'b0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_lives   <= '0;
      r_hex0    <= 4'h0;
      r_ingame  <= 1'b0;
      r_over    <= 1'b0;
      r_ledr    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start;
      r_quit_q  <= userquit;
      r_tens    <= w_tens_next;
      r_ones    <= w_ones_next;
      r_lives   <= w_lives_next;
      r_hex0    <= w_hex0_next;
      r_ingame  <= (w_state_next == S_PLAY);
      r_over    <= (w_state_next == S_OVER);
      r_ledr    <= (w_state_next == S_PLAY || (w_state_next == S_OVER && !w_blank))
                   ? w_therm : '0;
    end
  end

  assign ingameOn = r_ingame;
  assign gameOver = r_over;
  assign hex0hldr = r_hex0;
  assign hex4hldr = r_ones;
  assign hex5hldr = r_tens;
  assign ledrhldr = r_ledr;

endmodule
